// File: rtl/uart_tx_fifo_pkg.sv
// Shared constants for the UART transmit path: default widths and the
// launch-FSM state encoding used by uart_tx_fifo.
package uart_tx_fifo_pkg;

  localparam int NB_DATA_DEF = 8;
  localparam int NB_ADDR_DEF = 4;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_WAIT_DONE = 1'b1
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo_mem.sv
// sync_fifo_mem: circular byte store with push/pop interface, NB_ADDR-bit
// wrapping pointers and a separate NB_ADDR+1 occupancy counter.
// A push while full and a pop while empty are ignored.
// The read port is combinational from rd_ptr.
module sync_fifo_mem
  import uart_tx_fifo_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_ADDR = NB_ADDR_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [NB_DATA-1:0] i_wr_data,
  output logic [NB_DATA-1:0] o_rd_data,
  output logic               o_full,
  output logic               o_empty,
  output logic [NB_ADDR:0]   o_count
);

  localparam int DEPTH = 2 ** NB_ADDR;
  localparam logic [NB_ADDR:0]   CNT_FULL = {1'b1, {NB_ADDR{1'b0}}};
  localparam logic [NB_ADDR:0]   CNT_ONE  = 1;
  localparam logic [NB_ADDR-1:0] PTR_ONE  = 1;

  logic [NB_DATA-1:0] mem_q [DEPTH];
  logic [NB_ADDR-1:0] wr_ptr_q, wr_ptr_d;
  logic [NB_ADDR-1:0] rd_ptr_q, rd_ptr_d;
  logic [NB_ADDR:0]   count_q, count_d;
  logic               push_ok, pop_ok;

  assign o_full    = (count_q == CNT_FULL);
  assign o_empty   = (count_q == '0);
  assign o_count   = count_q;
  assign o_rd_data = mem_q[rd_ptr_q];

  // Qualify requests against the pre-edge full/empty state and step pointers/count.
  always_comb begin
    push_ok  = i_push && !o_full;
    pop_ok   = i_pop && !o_empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care after reset.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffers result bytes from the interface and launches them
// one per frame into uart_tx via the tx_start/tx_done handshake.
// Optional macro UART_TX_FIFO_OVERFLOW_EN adds a sticky overflow flag
// (o_overflow) and its clear input (i_ovf_clr).
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_ADDR = NB_ADDR_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_wr,
  output logic               o_full,
  output logic               o_empty,
  output logic [NB_ADDR:0]   o_count,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_busy
`ifdef UART_TX_FIFO_OVERFLOW_EN
  ,
  output logic               o_overflow,
  input  logic               i_ovf_clr
`endif
);

  tx_state_e          state_q, state_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               pop;
  logic [NB_DATA-1:0] rd_data;

  sync_fifo_mem #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_mem (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_push    (i_wr),
    .i_pop     (pop),
    .i_wr_data (i_data),
    .o_rd_data (rd_data),
    .o_full    (o_full),
    .o_empty   (o_empty),
    .o_count   (o_count)
  );

  // Launch FSM: pop and fire a one-cycle start from IDLE, then wait for done.
  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!o_empty) begin
          pop        = 1'b1;
          tx_data_d  = rd_data;
          tx_start_d = 1'b1;
          state_d    = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (i_tx_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and registered uart_tx interface.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = (state_q == ST_WAIT_DONE);

`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic ovf_q, ovf_d;

  // Sticky overflow: any write while full sets it; set wins over clear.
  always_comb begin
    ovf_d = ovf_q;
    if (i_ovf_clr)       ovf_d = 1'b0;
    if (i_wr && o_full)  ovf_d = 1'b1;
  end

  // Overflow flag register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign o_overflow = ovf_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo with a queue-based reference model and
// a per-cycle compare process, plus directed literal checks.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] i_data = 8'h00;
  logic       i_wr = 1'b0;
  logic       i_tx_done = 1'b0;
  logic       o_full, o_empty, o_tx_start, o_busy;
  logic [4:0] o_count;
  logic [7:0] o_tx_data;
`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic       o_overflow;
  logic       i_ovf_clr = 1'b0;
  bit         m_ovf = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: queue of stored bytes, in-flight flag, launched byte.
  byte unsigned q[$];
  bit           m_busy  = 1'b0;
  bit           m_start = 1'b0;
  logic [7:0]   m_data  = 8'h00;
  int           tmr     = 0;
  logic [7:0]   start_log[$];

  always #5 clk = ~clk;

  uart_tx_fifo #(.NB_DATA(8), .NB_ADDR(4)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_data     (i_data),
    .i_wr       (i_wr),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_count    (o_count),
    .o_tx_data  (o_tx_data),
    .o_tx_start (o_tx_start),
    .i_tx_done  (i_tx_done),
    .o_busy     (o_busy)
`ifdef UART_TX_FIFO_OVERFLOW_EN
    ,
    .o_overflow (o_overflow),
    .i_ovf_clr  (i_ovf_clr)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_busy  = 1'b0;
    m_start = 1'b0;
    m_data  = 8'h00;
    tmr     = 0;
`ifdef UART_TX_FIFO_OVERFLOW_EN
    m_ovf   = 1'b0;
`endif
  endtask

  // Advance the model by one rising edge using the inputs held across it.
  task automatic model_update();
    bit was_full;
    if (rst) begin
      model_clear();
      return;
    end
    was_full = (q.size() == 16);
    m_start  = 1'b0;
    if (!m_busy && q.size() > 0) begin
      m_data  = q.pop_front();
      m_busy  = 1'b1;
      m_start = 1'b1;
    end else if (m_busy && i_tx_done) begin
      m_busy = 1'b0;
    end
    if (i_wr && !was_full) q.push_back(i_data);
`ifdef UART_TX_FIFO_OVERFLOW_EN
    if (i_ovf_clr) m_ovf = 1'b0;
    if (i_wr && was_full) m_ovf = 1'b1;
`endif
  endtask

  // Drive one cycle: inputs set now, model advanced at the edge, return at negedge.
  task automatic step(input logic wr, input logic [7:0] d, input logic done);
    i_wr      = wr;
    i_data    = d;
    i_tx_done = done;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  // One cycle where uart_tx answers done `delay` cycles after each start.
  task automatic frame_cycle(input logic wr, input logic [7:0] d, input int delay);
    logic done;
    done = m_busy && !m_start && (tmr == 0);
    step(wr, d, done);
    if (m_start) tmr = delay;
    else if (tmr > 0) tmr--;
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_count", o_count, 0);
    chk("rst_empty", o_empty, 1);
    chk("rst_full", o_full, 0);
    chk("rst_start", o_tx_start, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_data", o_tx_data, 0);
    model_clear();
    step(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("count", o_count, q.size());
    chk("empty", o_empty, q.size() == 0);
    chk("full", o_full, q.size() == 16);
    chk("busy", o_busy, m_busy);
    chk("tx_start", o_tx_start, m_start);
    chk("tx_data", o_tx_data, m_data);
`ifdef UART_TX_FIFO_OVERFLOW_EN
    chk("overflow", o_overflow, m_ovf);
`endif
    if (o_tx_start) start_log.push_back(o_tx_data);
  end

  initial begin
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset asserted between edges takes effect immediately.
    async_reset();

    // Single byte latency.
    step(1'b1, 8'hA5, 1'b0);
    chk("single_start_e0", o_tx_start, 0);
    chk("single_count_e0", o_count, 1);
    step(1'b0, 8'h00, 1'b0);
    chk("single_start_e1", o_tx_start, 1);
    chk("single_data", o_tx_data, 8'hA5);
    chk("single_busy", o_busy, 1);
    step(1'b0, 8'h00, 1'b0);
    chk("single_pulse_len", o_tx_start, 0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0);
    chk("single_hold_data", o_tx_data, 8'hA5);
    step(1'b0, 8'h00, 1'b1);
    chk("single_done_busy", o_busy, 0);
    chk("single_done_empty", o_empty, 1);

    // Burst order with done 20 cycles after each start.
    start_log.delete();
    for (int i = 1; i <= 5; i++) frame_cycle(1'b1, 8'(i), 20);
    for (int i = 0; i < 130; i++) frame_cycle(1'b0, 8'h00, 20);
    chk("burst_nstarts", start_log.size(), 5);
    for (int i = 0; i < 5 && i < start_log.size(); i++)
      chk("burst_order", start_log[i], i + 1);

    // Fill to full with done held low; the 18th byte is dropped.
    for (int i = 0; i < 18; i++) step(1'b1, 8'h10 + 8'(i), 1'b0);
    chk("full_count", o_count, 16);
    chk("full_flag", o_full, 1);
    chk("full_inflight", o_tx_data, 8'h10);
    chk("full_tail", q[15], 8'h20);
`ifdef UART_TX_FIFO_OVERFLOW_EN
    chk("ovf_set", o_overflow, 1);
    step(1'b0, 8'h00, 1'b0);
    chk("ovf_sticky", o_overflow, 1);
    i_ovf_clr = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    i_ovf_clr = 1'b0;
    chk("ovf_clr", o_overflow, 0);
`endif
    tmr = 0;
    for (int i = 0; i < 60; i++) frame_cycle(1'b0, 8'h00, 1);
    chk("full_drained", o_empty, 1);

    // Simultaneous write and pop at count 3.
    for (int i = 0; i < 4; i++) step(1'b1, 8'h30 + 8'(i), 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk("sim_pre_count", o_count, 3);
    step(1'b1, 8'h3F, 1'b0);
    chk("sim_count", o_count, 3);
    chk("sim_start", o_tx_start, 1);
    chk("sim_data", o_tx_data, 8'h31);

    // 40 mixed operations across pointer wrap.
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));

    // Longer random phases: mostly-filling then mostly-draining.
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 3) != 0), 8'($urandom),
           m_busy ? 1'($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 7) == 0));
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 3) == 0), 8'($urandom),
           m_busy ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 7) == 0));

    // Reset in the middle of a frame discards everything.
    for (int i = 0; i < 30; i++) frame_cycle(1'b0, 8'h00, 1);
    for (int i = 0; i < 4; i++) step(1'b1, 8'h50 + 8'(i), 1'b0);
    chk("mid_busy", o_busy, 1);
    async_reset();
    start_log.delete();
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b0);
    chk("mid_nstarts", start_log.size(), 0);
    chk("mid_empty", o_empty, 1);
    chk("mid_busy_after", o_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
